hwpe_evt_irq_ctrl: RTL and testbench
====================================

# hwpe_evt_irq_ctrl

Interrupt controller between the HWPE subsystem's per-core event outputs and the Snitch cluster's `mxip_i` inputs inside the cluster tile. It captures HWPE completion events into per-core pending bits and masks them with a software enable. It drives the masked result to the cores as machine external interrupts. Software configures it through a 32-bit TCDM-style peripheral port hung off the cluster's narrow external path.

## Interface
Parameters:
- `NrCores`, 9, number of cores, i.e. the width of the event and interrupt vectors; legal range 1..32.
- `AddrWidth`, 32, peripheral address width.
- `DataWidth`, 32, peripheral data width; fixed at 32.
- `CntWidth`, 16, width of the event counter.

Ports:
- `clk_i`  in  1  sole clock; all flops rising-edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `evt_i`  in  NrCores  HWPE event lines; level or pulse, synchronous to `clk_i`.
- `mxip_o`  out  NrCores  per-core interrupt to the cluster; registered.
- `req_i`  in  1  peripheral request valid.
- `add_i`  in  AddrWidth  byte address; only bits [4:2] decoded.
- `write_i`  in  1  1 = write, 0 = read.
- `wdata_i`  in  32  write data.
- `be_i`  in  4  byte enables for writes.
- `gnt_o`  out  1  grant.
- `rvalid_o`  out  1  response valid.
- `rdata_o`  out  32  read data.
- `err_o`  out  1  response error, qualified by `rvalid_o`.

## Operation
- **Register map** (word offset via add_i[4:2]); register bits above NrCores-1 read 0 and ignore writes:
  - 0x00 PENDING, read-only: the pending bits.
  - 0x04 ENABLE, read/write: reset value all-ones over NrCores.
  - 0x08 CLEAR, write-only, write 1 to clear pending; reads 0.
  - 0x0C SET, write-only, write 1 to set pending; reads 0.
  - 0x10 COUNT, saturating count of captured events; any write clears it to 0.
  - 0x14 MODE, bit0 only: 0 = edge mode (reset value), 1 = level mode.
  - 0x18 and 0x1C: `err_o`=1, `rdata_o`=0, no state change.
- **Edge detection:** `evt_q` is a register holding the previous `evt_i`; reset 0. A rising edge is `evt_i & ~evt_q`.
- **Edge mode:**
  - A rising edge sets the pending bit.
  - CLEAR and SET act in the same cycle as the write grant.
  - Priority per bit: capture or SET wins over CLEAR, so no event is lost.
  - Next `mxip_o` = next pending & next enable.
- **Level mode:**
  - Next `mxip_o` = `evt_i` & next enable.
  - Pending bits still capture edges and remain software-visible.
- **COUNT:**
  - Adds the popcount of rising edges each cycle, before masking by ENABLE.
  - The popcount is zero-extended to CntWidth and the sum saturates at 2^CntWidth-1.
  - SET writes do not count.
  - A write to COUNT in the same cycle as a capture leaves COUNT at 0; the captures of that cycle are dropped from the count.
- **Byte enables:** writes update only bytes whose `be_i` bit is set. CLEAR and SET consider only the enabled bytes.

## Timing
- Reset values: `mxip_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, pending=0, COUNT=0, MODE=0, ENABLE=all-ones.
- Handshake:
  - `gnt_o` = `req_i`, combinational; the block never stalls.
  - Each granted request yields exactly one cycle with `rvalid_o`=1, at the next clock edge. Writes get a response too.
  - `rdata_o` carries pre-write register state sampled at the grant cycle. It is held until the next response.
  - Back-to-back requests give back-to-back responses.
- Latency:
  - `evt_i` high in cycle n → pending set and `mxip_o` high in cycle n+1.
  - An ENABLE, CLEAR or SET write granted in cycle n → effect on `mxip_o` visible in cycle n+1.
- An `evt_i` held high produces exactly one capture. A new capture requires `evt_i` to go low for at least one cycle.
- Reset asserted mid-transaction: the pending response is discarded and all state returns to reset values asynchronously.

## Configuration
- `HWPE_EVT_CNT_EN`, when defined: the COUNT register and its CntWidth counter are present, as described above.
- When undefined: no counter logic is present. Reads of 0x10 return 0 with `err_o`=0, and writes are accepted and ignored.

## Test plan
- **Reset and default enable:** with NrCores=9, assert reset, then pulse `evt_i`=9'h004 for one cycle. Expect `mxip_o`=9'h004 one cycle later; reading PENDING returns 0x004; after writing CLEAR=0x004, `mxip_o` is 0 one cycle after the grant.
- **Masking:** write ENABLE=0x000, then pulse `evt_i`=9'h1FF. Expect `mxip_o` to stay 0 and PENDING to read 0x1FF. Then write ENABLE=0x0F0 and expect `mxip_o`=9'h0F0 the next cycle.
- **Simultaneous capture and clear:** in the same cycle, write CLEAR=0x001 and have a rising edge on `evt_i[0]`. Expect PENDING bit 0 to remain 1.
- **Counter** (with `HWPE_EVT_CNT_EN` and CntWidth=4): apply 20 single-bit rising edges. Expect COUNT to read 15 (saturated). Write COUNT and expect a read to return 0.
- **Level mode and errors:** write MODE=1 and hold `evt_i`=9'h003 for 5 cycles. Expect `mxip_o`=9'h003 throughout, falling to 0 one cycle after `evt_i` drops. A read of 0x1C returns `err_o`=1 and `rdata_o`=0.
- **Handshake:** issue four back-to-back reads with `be_i`=4'h0. Expect four consecutive `rvalid_o` cycles. A write with `be_i`=4'h1 to ENABLE changes only bits [7:0].

Source files
------------

// File: rtl/hwpe_evt_irq_ctrl.sv
// Purpose : captures HWPE per-core events into pending bits, masks with ENABLE, drives mxip_o.
// Latency : evt_i / register writes in cycle n reach mxip_o in cycle n+1; responses 1 cycle after grant.
// Backpr. : none, gnt_o = req_i and every granted request gets exactly one rvalid_o pulse.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   evt_i   [NrCores]     HWPE event lines (level or pulse, synchronous)
//   mxip_o  [NrCores]     registered machine external interrupt per core
//   req_i/add_i/write_i/wdata_i/be_i   TCDM-style peripheral request
//   gnt_o/rvalid_o/rdata_o/err_o       grant and one-cycle-later response
//
// Register map (word offset add_i[4:2]):
//   0x00 PENDING (ro)  0x04 ENABLE (rw)  0x08 CLEAR (wo, W1C)  0x0C SET (wo, W1S)
//   0x10 COUNT         0x14 MODE (bit0: 0 edge, 1 level)       0x18/0x1C error
//
// Build option: define HWPE_EVT_CNT_EN to include the saturating COUNT register.
// Without it, 0x10 reads 0 with no error and writes are accepted and ignored.

module hwpe_evt_irq_ctrl #(
  parameter int unsigned NrCores   = 9,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NrCores-1:0]       evt_i,
  output logic [NrCores-1:0]       mxip_o,
  input  logic                     req_i,
  input  logic [AddrWidth-1:0]     add_i,
  input  logic                     write_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic [DataWidth/8-1:0]   be_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [DataWidth-1:0]     rdata_o,
  output logic                     err_o
);

  localparam logic [2:0] RegPending = 3'd0;
  localparam logic [2:0] RegEnable  = 3'd1;
  localparam logic [2:0] RegClear   = 3'd2;
  localparam logic [2:0] RegSet     = 3'd3;
  localparam logic [2:0] RegCount   = 3'd4;
  localparam logic [2:0] RegMode    = 3'd5;

  // State
  logic [NrCores-1:0]   evt_q;
  logic [NrCores-1:0]   pending_q;
  logic [NrCores-1:0]   enable_q;
  logic [NrCores-1:0]   mxip_q;
  logic                 mode_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;

  // Next-state and decode
  logic [2:0]           word;
  logic                 wr_en;
  logic [DataWidth-1:0] be_mask;
  logic [NrCores-1:0]   be_bits;
  logic [NrCores-1:0]   wr_bits;
  logic [NrCores-1:0]   rise;
  logic [NrCores-1:0]   clr_bits;
  logic [NrCores-1:0]   set_bits;
  logic [NrCores-1:0]   enable_d;
  logic [NrCores-1:0]   pending_d;
  logic [NrCores-1:0]   mxip_d;
  logic                 mode_d;
  logic                 cnt_clr;
  logic [DataWidth-1:0] cnt_rd;
  logic [DataWidth-1:0] rdata_d;
  logic                 err_d;

  assign gnt_o    = req_i;
  assign word     = add_i[4:2];
  assign wr_en    = req_i & write_i;
  assign rise     = evt_i & ~evt_q;
  assign mxip_o   = mxip_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Expand byte enables to a bit mask so ENABLE/CLEAR/SET only see enabled bytes.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < DataWidth/8; b++) begin
      be_mask[b*8 +: 8] = {8{be_i[b]}};
    end
  end

  assign be_bits = be_mask[NrCores-1:0];
  assign wr_bits = wdata_i[NrCores-1:0] & be_bits;

  // Write decode
  always_comb begin
    clr_bits = '0;
    set_bits = '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    cnt_clr  = 1'b0;
    if (wr_en) begin
      case (word)
        RegEnable: enable_d = (enable_q & ~be_bits) | wr_bits;
        RegClear:  clr_bits = wr_bits;
        RegSet:    set_bits = wr_bits;
        RegCount:  cnt_clr  = 1'b1;
        RegMode:   if (be_i[0]) mode_d = wdata_i[0];
        default:   ;
      endcase
    end
  end

  // Capture and SET are OR-ed in after CLEAR so a same-cycle event is never lost.
  assign pending_d = (pending_q & ~clr_bits) | set_bits | rise;

  // Level mode bypasses pending and follows the raw event lines; pending still
  // records edges for software in both modes.
  assign mxip_d = mode_d ? (evt_i & enable_d) : (pending_d & enable_d);

  // Read mux: pre-write state at the grant cycle.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    case (word)
      RegPending: rdata_d[NrCores-1:0] = pending_q;
      RegEnable:  rdata_d[NrCores-1:0] = enable_q;
      RegCount:   rdata_d              = cnt_rd;
      RegMode:    rdata_d[0]           = mode_q;
      3'd6, 3'd7: err_d                = 1'b1;
      default:    ;
    endcase
  end

`ifdef HWPE_EVT_CNT_EN
  // The popcount of at most 32 edges fits in 6 bits; summing 6 bits wider
  // than the counter means the saturation test never sees a wrapped value.
  localparam int unsigned SumWidth = CntWidth + 6;
  localparam logic [SumWidth-1:0] CntMax = {6'd0, {CntWidth{1'b1}}};

  logic [CntWidth-1:0] cnt_q;
  logic [5:0]          rise_cnt;
  logic [SumWidth-1:0] cnt_sum;
  logic [CntWidth-1:0] cnt_d;

  always_comb begin
    rise_cnt = '0;
    for (int i = 0; i < NrCores; i++) begin
      rise_cnt = rise_cnt + 6'(rise[i]);
    end
  end

  assign cnt_sum = {6'd0, cnt_q} + {{(SumWidth-6){1'b0}}, rise_cnt};

  // A clearing write wins over captures of the same cycle.
  always_comb begin
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_sum > CntMax) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[CntWidth-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_rd = DataWidth'(cnt_q);
`else
  logic unused_cnt;
  assign unused_cnt = cnt_clr;
  assign cnt_rd     = '0;
`endif

  // Address bits outside [4:2] and data bits above NrCores are don't-care.
  logic unused_bits;
  assign unused_bits = ^{add_i, wdata_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q     <= '0;
      pending_q <= '0;
      enable_q  <= '1;
      mode_q    <= 1'b0;
      mxip_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      evt_q     <= evt_i;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      mxip_q    <= mxip_d;
      rvalid_q  <= req_i;
      // Response data is held until the next granted request.
      if (req_i) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_hwpe_evt_irq_ctrl.sv
// Purpose : self-checking bench for hwpe_evt_irq_ctrl, directed scenarios plus random traffic.
// Latency : compares DUT outputs 1ns after each rising edge against a cycle-level behavioural model.
// Backpr. : none expected; gnt_o is checked to equal req_i every cycle.

module tb_hwpe_evt_irq_ctrl;

  localparam int NC = 9;
  localparam int CW = 4;

  logic          clk_i;
  logic          rst_i;
  logic [NC-1:0] evt_i;
  logic [NC-1:0] mxip_o;
  logic          req_i;
  logic [31:0]   add_i;
  logic          write_i;
  logic [31:0]   wdata_i;
  logic [3:0]    be_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;

  hwpe_evt_irq_ctrl #(
    .NrCores  (NC),
    .AddrWidth(32),
    .DataWidth(32),
    .CntWidth (CW)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .evt_i   (evt_i),
    .mxip_o  (mxip_o),
    .req_i   (req_i),
    .add_i   (add_i),
    .write_i (write_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one bit array per register, integer counter.
  bit [NC-1:0] m_pend, m_en, m_prev;
  bit          m_mode;
  int          m_cnt;
  bit [NC-1:0] e_mxip;
  bit          e_rvalid, e_err;
  bit [31:0]   e_rdata;

  task automatic model_reset();
    m_pend = '0; m_en = '1; m_prev = '0; m_mode = 0; m_cnt = 0;
    e_mxip = '0; e_rvalid = 0; e_err = 0; e_rdata = '0;
  endtask

  task automatic model_step(input bit [NC-1:0] evt, input bit req, input bit wr,
                            input bit [2:0] w, input bit [31:0] wd, input bit [3:0] be);
    int edges;
    bit [NC-1:0] rise;
    edges = 0;
    for (int i = 0; i < NC; i++) begin
      rise[i] = evt[i] && !m_prev[i];
      if (rise[i]) edges++;
    end
    // Response reflects the register file before this cycle's write.
    e_rvalid = req;
    if (req) begin
      e_err   = (w >= 6);
      e_rdata = 0;
      case (w)
        0: e_rdata = 32'(m_pend);
        1: e_rdata = 32'(m_en);
`ifdef HWPE_EVT_CNT_EN
        4: e_rdata = 32'(m_cnt);
`endif
        5: e_rdata = 32'(m_mode);
        default: e_rdata = 0;
      endcase
    end
    // Counter: edges add up and saturate; a COUNT write wipes them.
    if (req && wr && w == 4) m_cnt = 0;
    else m_cnt = (m_cnt + edges > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + edges;
    for (int i = 0; i < NC; i++) begin
      bit ben;
      ben = be[i / 8];
      if (req && wr && ben) begin
        if (w == 1) m_en[i] = wd[i];
        if (w == 2 && wd[i]) m_pend[i] = 0;
      end
      if (rise[i]) m_pend[i] = 1;
      if (req && wr && ben && w == 3 && wd[i]) m_pend[i] = 1;
    end
    if (req && wr && w == 5 && be[0]) m_mode = wd[0];
    e_mxip = m_mode ? (evt & m_en) : (m_pend & m_en);
    m_prev = evt;
  endtask

  // One clock cycle: drive at the falling edge, check 1ns after the rising edge.
  task automatic drive(input bit [NC-1:0] evt, input bit req, input bit wr,
                       input bit [2:0] w, input bit [31:0] wd, input bit [3:0] be);
    bit [31:0] a;
    a = $urandom();
    a[4:2] = w;
    evt_i = evt; req_i = req; write_i = wr; add_i = a; wdata_i = wd; be_i = be;
    #1;
    check("gnt", 32'(gnt_o), 32'(req));
    model_step(evt, req, wr, w, wd, be);
    @(posedge clk_i);
    #1;
    check("mxip", 32'(mxip_o), 32'(e_mxip));
    check("rvalid", 32'(rvalid_o), 32'(e_rvalid));
    check("rdata", rdata_o, e_rdata);
    if (e_rvalid) check("err", 32'(err_o), 32'(e_err));
    @(negedge clk_i);
  endtask

  task automatic idle(input bit [NC-1:0] evt);
    drive(evt, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_reg(input bit [NC-1:0] evt, input bit [2:0] w, input bit [31:0] wd);
    drive(evt, 1, 1, w, wd, 4'hF);
  endtask
  task automatic rd_reg(input bit [NC-1:0] evt, input bit [2:0] w);
    drive(evt, 1, 0, w, $urandom(), 4'hF);
  endtask

  initial begin
    bit [NC-1:0] evt_r;
    evt_i = '0; req_i = 0; write_i = 0; add_i = '0; wdata_i = '0; be_i = '0;
    rst_i = 1'b1;
    model_reset();
    #12;
    check("rst_mxip", 32'(mxip_o), 0);
    check("rst_rvalid", 32'(rvalid_o), 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", 32'(err_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Default enable lets a single event straight through.
    idle(9'h004);
    check("t1_mxip", 32'(mxip_o), 32'h004);
    rd_reg(9'h000, 0);
    check("t1_pend", rdata_o, 32'h004);
    wr_reg(9'h000, 2, 32'h004);
    check("t1_clr", 32'(mxip_o), 0);

    // Masking.
    wr_reg(9'h000, 1, 32'h000);
    idle(9'h1FF);
    check("t2_mask", 32'(mxip_o), 0);
    idle(9'h000);
    rd_reg(9'h000, 0);
    check("t2_pend", rdata_o, 32'h1FF);
    wr_reg(9'h000, 1, 32'h0F0);
    check("t2_en", 32'(mxip_o), 32'h0F0);

    // Capture beats a same-cycle clear.
    wr_reg(9'h001, 2, 32'h001);
    rd_reg(9'h000, 0);
    check("t3_pend0", 32'(rdata_o[0]), 1);

    // Counter saturation and clear.
    wr_reg(9'h000, 4, 32'h0);
    for (int k = 0; k < 20; k++) begin
      idle(NC'(1) << (k % NC));
      idle(9'h000);
    end
    rd_reg(9'h000, 4);
`ifdef HWPE_EVT_CNT_EN
    check("t4_sat", rdata_o, 32'd15);
`else
    check("t4_nocnt", rdata_o, 32'd0);
`endif
    wr_reg(9'h000, 4, 32'hFFFF_FFFF);
    rd_reg(9'h000, 4);
    check("t4_clr", rdata_o, 0);

    // Level mode and error decode.
    wr_reg(9'h000, 1, 32'h1FF);
    wr_reg(9'h000, 5, 32'h1);
    for (int k = 0; k < 5; k++) begin
      idle(9'h003);
      check("t5_lvl", 32'(mxip_o), 32'h003);
    end
    idle(9'h000);
    check("t5_drop", 32'(mxip_o), 0);
    rd_reg(9'h000, 7);
    check("t5_err", 32'(err_o), 1);
    check("t5_errdat", rdata_o, 0);
    rd_reg(9'h000, 6);

    // Back-to-back reads with no byte enables, then a partial ENABLE write.
    for (int k = 0; k < 4; k++) begin
      drive(9'h000, 1, 0, 3'(k), 0, 4'h0);
      check("t6_b2b", 32'(rvalid_o), 1);
    end
    drive(9'h000, 1, 1, 1, 32'h0, 4'h1);
    rd_reg(9'h000, 1);
    check("t6_be", rdata_o, 32'h100);
    wr_reg(9'h000, 5, 32'h0);

    // Reset in the middle of a granted request drops the response.
    evt_i = 9'h0AA; req_i = 1; write_i = 0; add_i = 32'h0000_0004;
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_mxip", 32'(mxip_o), 0);
    check("arst_rvalid", 32'(rvalid_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    check("arst_hold", 32'(rvalid_o), 0);
    @(negedge clk_i);
    req_i = 0; evt_i = '0;
    rst_i = 1'b0;
    rd_reg(9'h000, 1);
    check("arst_en", rdata_o, 32'h1FF);

    // Random traffic against the model.
    evt_r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) evt_r = NC'($urandom());
      drive(evt_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), $urandom(), 4'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
